// File: rtl/misao_branch_unit_if.sv
// Decoder <-> branch unit bundle: control-flow requests and flags in,
// fetch PC and return-stack status out.
interface misao_branch_unit_if #(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned LINK_DEPTH = 4
);
  localparam int unsigned DEPTH_W = $clog2(LINK_DEPTH + 1);

  logic                step;
  logic                br_valid;
  logic [2:0]          br_kind;
  logic [1:0]          br_width;
  logic [1:0]          br_scale;
  logic [15:0]         br_off;
  logic [ADDR_W-1:0]   br_pc;
  logic                acc_zero;
  logic                carry;
  logic [ADDR_W-1:0]   jmp_target;

  logic [ADDR_W-1:0]   fetch_addr;
  logic                nib_sel;
  logic                redirect;
  logic                taken;
  logic [ADDR_W-1:0]   link_top;
  logic [DEPTH_W-1:0]  stk_depth;
  logic                stk_ovf;
  logic                stk_unf;

  modport master (
    output step, br_valid, br_kind, br_width, br_scale, br_off, br_pc,
           acc_zero, carry, jmp_target,
    input  fetch_addr, nib_sel, redirect, taken, link_top, stk_depth,
           stk_ovf, stk_unf
  );

  modport slave (
    input  step, br_valid, br_kind, br_width, br_scale, br_off, br_pc,
           acc_zero, carry, jmp_target,
    output fetch_addr, nib_sel, redirect, taken, link_top, stk_depth,
           stk_ovf, stk_unf
  );
endinterface

// File: rtl/misao_branch_unit.sv
// MISA-O program counter and control-flow unit: nibble-granular PC, relative and
// absolute branches, and a circular hardware return stack with sticky error flags.
module misao_branch_unit #(
  parameter int unsigned       ADDR_W     = 15,
  parameter int unsigned       LINK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input logic                clk,
  input logic                rst,
  misao_branch_unit_if.slave bus
);
  localparam int unsigned        DEPTH_W    = $clog2(LINK_DEPTH + 1);
  localparam int unsigned        PTR_W      = (LINK_DEPTH > 1) ? $clog2(LINK_DEPTH) : 1;
  localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(LINK_DEPTH - 1);
  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(LINK_DEPTH);
  localparam logic [ADDR_W:0]    PC_ONE     = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    KIND_BEQZ = 3'd0,
    KIND_BNEZ = 3'd1,
    KIND_BC   = 3'd2,
    KIND_JMP  = 3'd3,
    KIND_JAL  = 3'd4,
    KIND_RET  = 3'd5
  } br_kind_e;

  // PC is {byte address, nibble select}, so a plain increment walks nibbles.
  logic [ADDR_W:0]       pc_q;
  logic                  redirect_q;
  logic                  taken_q;

  logic [ADDR_W-1:0]     stack_mem [LINK_DEPTH];
  logic [PTR_W-1:0]      top_ptr;
  logic [DEPTH_W-1:0]    depth_q;
  logic                  ovf_q;
  logic                  unf_q;

  logic [ADDR_W-1:0]     off_ext;
  logic [ADDR_W-1:0]     offset;
  logic [ADDR_W-1:0]     rel_target;
  logic [ADDR_W-1:0]     link_ret;
  logic [ADDR_W-1:0]     link_top;
  logic [PTR_W-1:0]      ptr_inc;
  logic [PTR_W-1:0]      ptr_dec;
  logic                  stack_full;
  logic                  stack_empty;

  logic                  resolved;
  logic                  do_redirect;
  logic                  push;
  logic                  pop;
  logic [ADDR_W-1:0]     target;

  // Sign-extend straight to ADDR_W; truncation then gives the modular wrap.
  always_comb begin
    unique case (bus.br_width)
      2'd1:    off_ext = ADDR_W'($signed(bus.br_off[7:0]));
      2'd2:    off_ext = ADDR_W'($signed(bus.br_off));
      default: off_ext = ADDR_W'($signed(bus.br_off[3:0]));
    endcase
  end

  assign offset      = off_ext << bus.br_scale;
  assign link_ret    = bus.br_pc + ADDR_W'(1);
  assign rel_target  = link_ret + offset;
  assign stack_full  = (depth_q == DEPTH_FULL);
  assign stack_empty = (depth_q == '0);
  assign ptr_inc     = (top_ptr == PTR_LAST) ? '0 : top_ptr + PTR_W'(1);
  assign ptr_dec     = (top_ptr == '0) ? PTR_LAST : top_ptr - PTR_W'(1);
  assign link_top    = stack_empty ? '0 : stack_mem[top_ptr];

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    resolved    = 1'b0;
    do_redirect = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    target      = rel_target;
    if (bus.br_valid) begin
      unique case (bus.br_kind)
        KIND_BEQZ: begin resolved = 1'b1; do_redirect = bus.acc_zero;  end
        KIND_BNEZ: begin resolved = 1'b1; do_redirect = !bus.acc_zero; end
        KIND_BC:   begin resolved = 1'b1; do_redirect = bus.carry;     end
        KIND_JMP: begin
          resolved    = 1'b1;
          do_redirect = 1'b1;
          target      = bus.jmp_target;
        end
        KIND_JAL: begin
          resolved    = 1'b1;
          do_redirect = 1'b1;
          target      = bus.jmp_target;
          push        = 1'b1;
        end
        KIND_RET: begin
          resolved    = 1'b1;
          do_redirect = 1'b1;
          target      = link_top;
          pop         = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= {RESET_PC, 1'b0};
      redirect_q <= 1'b0;
      taken_q    <= 1'b0;
    end else begin
      redirect_q <= do_redirect;
      if (resolved) taken_q <= do_redirect;
      if (do_redirect)   pc_q <= {target, 1'b0};
      else if (bus.step) pc_q <= pc_q + PC_ONE;
    end
  end

  // A push on a full stack lands on the oldest slot, which is the one after the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_ptr <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (push) begin
      top_ptr <= ptr_inc;
      if (stack_full) ovf_q   <= 1'b1;
      else            depth_q <= depth_q + DEPTH_W'(1);
    end else if (pop) begin
      if (stack_empty) begin
        unf_q <= 1'b1;
      end else begin
        top_ptr <= ptr_dec;
        depth_q <= depth_q - DEPTH_W'(1);
      end
    end
  end

  // NOTE: the link array is not reset; depth_q gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (!rst && push) stack_mem[ptr_inc] <= link_ret;
  end

  assign bus.fetch_addr = pc_q[ADDR_W:1];
  assign bus.nib_sel    = pc_q[0];
  assign bus.redirect   = redirect_q;
  assign bus.taken      = taken_q;
  assign bus.link_top   = link_top;
  assign bus.stk_depth  = depth_q;
  assign bus.stk_ovf    = ovf_q;
  assign bus.stk_unf    = unf_q;
endmodule

// File: tb/tb_misao_branch_unit.sv
// Self-checking bench for misao_branch_unit: directed scenarios plus random
// requests compared against a queue-based behavioural model.
module tb_misao_branch_unit;
  localparam int ADDR_W     = 15;
  localparam int LINK_DEPTH = 4;
  localparam int RESET_PC   = 0;
  localparam int PC_MOD     = 1 << ADDR_W;

  typedef struct {
    bit step;
    bit valid;
    int kind;
    int width;
    int scale;
    int off;
    int pc;
    bit acc_zero;
    bit carry;
    int target;
  } req_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  int   m_pc;
  int   m_stack[$];
  bit   m_ovf, m_unf, m_redirect, m_taken;

  misao_branch_unit_if #(.ADDR_W(ADDR_W), .LINK_DEPTH(LINK_DEPTH)) bus ();

  misao_branch_unit #(
    .ADDR_W(ADDR_W), .LINK_DEPTH(LINK_DEPTH), .RESET_PC(15'(RESET_PC))
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wrap(int x);
    return ((x % PC_MOD) + PC_MOD) % PC_MOD;
  endfunction

  function automatic int rel_offset(int width, int off, int scale);
    int bits = (width == 1) ? 8 : (width == 2) ? 16 : 4;
    int v    = off & ((1 << bits) - 1);
    if (v >= (1 << (bits - 1))) v -= (1 << bits);
    return v * (1 << scale);
  endfunction

  function automatic void model_reset();
    m_pc = RESET_PC * 2;
    m_stack.delete();
    m_ovf = 0; m_unf = 0; m_redirect = 0; m_taken = 0;
  endfunction

  function automatic void model_update(req_t r);
    bit redir    = 0;
    int tgt      = wrap(r.pc + 1 + rel_offset(r.width, r.off, r.scale));
    bit resolved = r.valid && (r.kind <= 5);
    if (r.valid) begin
      case (r.kind)
        0: redir = r.acc_zero;
        1: redir = !r.acc_zero;
        2: redir = r.carry;
        3: begin redir = 1; tgt = r.target; end
        4: begin
          redir = 1; tgt = r.target;
          if (m_stack.size() == LINK_DEPTH) begin
            void'(m_stack.pop_front());
            m_ovf = 1;
          end
          m_stack.push_back(wrap(r.pc + 1));
        end
        5: begin
          redir = 1;
          if (m_stack.size() == 0) begin tgt = 0; m_unf = 1; end
          else tgt = m_stack.pop_back();
        end
        default: ;
      endcase
    end
    if (resolved) m_taken = redir;
    m_redirect = redir;
    if (redir)       m_pc = tgt * 2;
    else if (r.step) m_pc = (m_pc + 1) % (2 * PC_MOD);
  endfunction

  function automatic req_t mk(bit step, bit valid, int kind, int width, int scale,
                              int off, int pc, bit acc_zero, bit carry, int target);
    req_t r;
    r.step = step; r.valid = valid; r.kind = kind; r.width = width; r.scale = scale;
    r.off = off; r.pc = pc; r.acc_zero = acc_zero; r.carry = carry; r.target = target;
    return r;
  endfunction

  // Drive at the falling edge, let the DUT sample on the rising edge, return at the next falling edge.
  task automatic apply(input req_t r, input bit do_rst);
    rst            = do_rst;
    bus.step       = r.step;
    bus.br_valid   = r.valid;
    bus.br_kind    = 3'(r.kind);
    bus.br_width   = 2'(r.width);
    bus.br_scale   = 2'(r.scale);
    bus.br_off     = 16'(r.off);
    bus.br_pc      = 15'(r.pc);
    bus.acc_zero   = r.acc_zero;
    bus.carry      = r.carry;
    bus.jmp_target = 15'(r.target);
    @(posedge clk);
    if (do_rst) model_reset();
    else        model_update(r);
    @(negedge clk);
    rst          = 1'b0;
    bus.step     = 1'b0;
    bus.br_valid = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    n_checks++; if (bus.fetch_addr !== 15'(RESET_PC)) $display("FAIL reset_addr: got %h want %h", bus.fetch_addr, 15'(RESET_PC)); else n_pass++;
    n_checks++; if (bus.nib_sel !== 1'b0) $display("FAIL reset_nib: got %b want 0", bus.nib_sel); else n_pass++;
    n_checks++; if (bus.redirect !== 1'b0 || bus.taken !== 1'b0) $display("FAIL reset_redirect_taken: got %b%b want 00", bus.redirect, bus.taken); else n_pass++;
    n_checks++; if (bus.stk_depth !== 3'd0 || bus.link_top !== 15'd0) $display("FAIL reset_stack: got depth %0d top %h want 0 0", bus.stk_depth, bus.link_top); else n_pass++;
    n_checks++; if (bus.stk_ovf !== 1'b0 || bus.stk_unf !== 1'b0) $display("FAIL reset_flags: got ovf %b unf %b want 0 0", bus.stk_ovf, bus.stk_unf); else n_pass++;
    for (int i = 0; i < 5; i++) apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    n_checks++; if (bus.fetch_addr !== 15'd2 || bus.nib_sel !== 1'b1) $display("FAIL step5: got %h.%b want 0002.1", bus.fetch_addr, bus.nib_sel); else n_pass++;
  endtask

  task automatic test_cond_branch();
    apply(mk(0, 1, 0, 0, 0, 2, 4, 1, 0, 0), 0);
    n_checks++; if (bus.fetch_addr !== 15'd7 || bus.nib_sel !== 1'b0) $display("FAIL beqz_taken: got %h.%b want 0007.0", bus.fetch_addr, bus.nib_sel); else n_pass++;
    n_checks++; if (bus.redirect !== 1'b1 || bus.taken !== 1'b1) $display("FAIL beqz_pulse: got redirect %b taken %b want 1 1", bus.redirect, bus.taken); else n_pass++;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    n_checks++; if (bus.redirect !== 1'b0) $display("FAIL beqz_pulse_end: got %b want 0", bus.redirect); else n_pass++;
    apply(mk(1, 1, 0, 0, 0, 2, 4, 0, 0, 0), 0);
    n_checks++; if (bus.fetch_addr !== 15'd7 || bus.nib_sel !== 1'b1 || bus.taken !== 1'b0 || bus.redirect !== 1'b0) $display("FAIL beqz_not_taken: got %h.%b t%b r%b want 0007.1 t0 r0", bus.fetch_addr, bus.nib_sel, bus.taken, bus.redirect); else n_pass++;
    apply(mk(0, 1, 2, 0, 1, 4'hF, 46, 0, 1, 0), 0);
    n_checks++; if (bus.fetch_addr !== 15'd45 || bus.taken !== 1'b1) $display("FAIL bc_taken: got %h t%b want %h t1", bus.fetch_addr, bus.taken, 15'd45); else n_pass++;
    apply(mk(1, 1, 2, 0, 1, 4'hF, 46, 0, 0, 0), 0);
    n_checks++; if (bus.fetch_addr !== 15'd45 || bus.nib_sel !== 1'b1 || bus.taken !== 1'b0) $display("FAIL bc_not_taken: got %h.%b t%b want %h.1 t0", bus.fetch_addr, bus.nib_sel, bus.taken, 15'd45); else n_pass++;
    apply(mk(0, 1, 1, 1, 0, 8'h80, 15'h0010, 0, 0, 0), 0);
    n_checks++; if (bus.fetch_addr !== 15'h7F91) $display("FAIL bnez_imm8_wrap: got %h want 7f91", bus.fetch_addr); else n_pass++;
  endtask

  task automatic test_priority();
    apply(mk(1, 1, 0, 0, 0, 1, 15'h0100, 1, 0, 0), 0);
    n_checks++; if (bus.fetch_addr !== 15'h0102 || bus.nib_sel !== 1'b0) $display("FAIL branch_beats_step: got %h.%b want 0102.0", bus.fetch_addr, bus.nib_sel); else n_pass++;
    apply(mk(1, 1, 6, 0, 0, 3, 15'h0200, 1, 1, 15'h0300), 0);
    n_checks++; if (bus.fetch_addr !== 15'h0102 || bus.nib_sel !== 1'b1 || bus.redirect !== 1'b0) $display("FAIL reserved_kind: got %h.%b r%b want 0102.1 r0", bus.fetch_addr, bus.nib_sel, bus.redirect); else n_pass++;
  endtask

  task automatic test_jal_ret();
    apply(mk(0, 1, 4, 0, 0, 0, 34, 0, 0, 15'h28), 0);
    n_checks++; if (bus.fetch_addr !== 15'h28 || bus.link_top !== 15'h23 || bus.stk_depth !== 3'd1) $display("FAIL jal: got %h top %h depth %0d want 0028 0023 1", bus.fetch_addr, bus.link_top, bus.stk_depth); else n_pass++;
    apply(mk(0, 1, 5, 0, 0, 0, 0, 0, 0, 0), 0);
    n_checks++; if (bus.fetch_addr !== 15'h23 || bus.stk_depth !== 3'd0 || bus.link_top !== 15'd0) $display("FAIL ret: got %h depth %0d top %h want 0023 0 0000", bus.fetch_addr, bus.stk_depth, bus.link_top); else n_pass++;
  endtask

  task automatic test_stack_limits();
    logic [14:0] exp_ret [4];
    exp_ret[0] = 15'h0F; exp_ret[1] = 15'h0E; exp_ret[2] = 15'h0D; exp_ret[3] = 15'h0C;
    for (int i = 0; i < 5; i++) apply(mk(0, 1, 4, 0, 0, 0, 10 + i, 0, 0, 15'h100), 0);
    n_checks++; if (bus.stk_depth !== 3'd4 || bus.stk_ovf !== 1'b1 || bus.link_top !== 15'h0F) $display("FAIL stack_overflow: got depth %0d ovf %b top %h want 4 1 000f", bus.stk_depth, bus.stk_ovf, bus.link_top); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      apply(mk(0, 1, 5, 0, 0, 0, 0, 0, 0, 0), 0);
      n_checks++; if (bus.fetch_addr !== exp_ret[i]) $display("FAIL ret_order_%0d: got %h want %h", i, bus.fetch_addr, exp_ret[i]); else n_pass++;
    end
    apply(mk(0, 1, 5, 0, 0, 0, 0, 0, 0, 0), 0);
    n_checks++; if (bus.fetch_addr !== 15'd0 || bus.stk_unf !== 1'b1 || bus.stk_depth !== 3'd0 || bus.stk_ovf !== 1'b1) $display("FAIL stack_underflow: got %h unf %b depth %0d ovf %b want 0000 1 0 1", bus.fetch_addr, bus.stk_unf, bus.stk_depth, bus.stk_ovf); else n_pass++;
  endtask

  task automatic test_wrap_and_rst();
    apply(mk(0, 1, 3, 0, 0, 0, 0, 0, 0, 15'h7FFF), 0);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    n_checks++; if (bus.fetch_addr !== 15'h7FFF || bus.nib_sel !== 1'b1) $display("FAIL pre_wrap: got %h.%b want 7fff.1", bus.fetch_addr, bus.nib_sel); else n_pass++;
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    n_checks++; if (bus.fetch_addr !== 15'd0 || bus.nib_sel !== 1'b0) $display("FAIL pc_wrap: got %h.%b want 0000.0", bus.fetch_addr, bus.nib_sel); else n_pass++;
    apply(mk(0, 1, 3, 0, 0, 0, 0, 0, 0, 15'h55), 0);
    apply(mk(0, 1, 4, 0, 0, 0, 15'h30, 0, 0, 15'h28), 1);
    n_checks++; if (bus.fetch_addr !== 15'(RESET_PC) || bus.stk_depth !== 3'd0 || bus.link_top !== 15'd0) $display("FAIL rst_vs_jal: got %h depth %0d top %h want %h 0 0000", bus.fetch_addr, bus.stk_depth, bus.link_top, 15'(RESET_PC)); else n_pass++;
    n_checks++; if (bus.stk_ovf !== 1'b0 || bus.stk_unf !== 1'b0 || bus.redirect !== 1'b0) $display("FAIL rst_clears_flags: got ovf %b unf %b r %b want 0 0 0", bus.stk_ovf, bus.stk_unf, bus.redirect); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req_t r;
      bit   do_rst;
      do_rst = ($urandom_range(0, 49) == 0);
      r = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)),
             int'($urandom_range(0, PC_MOD - 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, PC_MOD - 1)));
      apply(r, do_rst);
      n_checks++; if (bus.fetch_addr !== 15'(m_pc >> 1) || bus.nib_sel !== 1'(m_pc & 1)) $display("FAIL rand_pc[%0d]: got %h.%b want %h.%b", i, bus.fetch_addr, bus.nib_sel, 15'(m_pc >> 1), 1'(m_pc & 1)); else n_pass++;
      n_checks++; if (bus.redirect !== m_redirect || bus.taken !== m_taken) $display("FAIL rand_redirect[%0d]: got r%b t%b want r%b t%b", i, bus.redirect, bus.taken, m_redirect, m_taken); else n_pass++;
      n_checks++; if (bus.stk_depth !== 3'(m_stack.size()) || bus.link_top !== ((m_stack.size() == 0) ? 15'd0 : 15'(m_stack[$]))) $display("FAIL rand_stack[%0d]: got depth %0d top %h want %0d", i, bus.stk_depth, bus.link_top, m_stack.size()); else n_pass++;
      n_checks++; if (bus.stk_ovf !== m_ovf || bus.stk_unf !== m_unf) $display("FAIL rand_flags[%0d]: got ovf %b unf %b want %b %b", i, bus.stk_ovf, bus.stk_unf, m_ovf, m_unf); else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.step = 0; bus.br_valid = 0; bus.br_kind = 0; bus.br_width = 0; bus.br_scale = 0;
    bus.br_off = 0; bus.br_pc = 0; bus.acc_zero = 0; bus.carry = 0; bus.jmp_target = 0;
    model_reset();
    test_reset();
    test_cond_branch();
    test_priority();
    test_jal_ret();
    test_stack_limits();
    test_wrap_and_rst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
